// File: rtl/neural_frame_builder.sv
// Neural sample framer: stamps enabled samples with a timestamp, sequence number and
// drop flag, then queues them in a packet FIFO. Optional drop counter under NFB_DROP_CNT_EN.
module neural_frame_builder #(
  parameter int DATA_WIDTH  = 16,
  parameter int CH_ID_WIDTH = 4,
  parameter int TS_WIDTH    = 32,
  parameter int SEQ_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 8,
  localparam int NUM_CH     = 2**CH_ID_WIDTH,
  localparam int PKT_WIDTH  = TS_WIDTH + CH_ID_WIDTH + DATA_WIDTH + SEQ_WIDTH + 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic                   sensor_clk,
  input  logic                   sensor_rst,
  input  logic [DATA_WIDTH-1:0]  acq_data,
  input  logic [CH_ID_WIDTH-1:0] acq_channel,
  input  logic                   acq_valid,
  input  logic [NUM_CH-1:0]      ch_enable,
  output logic [PKT_WIDTH-1:0]   pkt_data,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic [LVL_W-1:0]       fifo_level
`ifdef NFB_DROP_CNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  logic [TS_WIDTH-1:0]                 ts_q, ts_d;
  logic [SEQ_WIDTH-1:0]                seq_q, seq_d;
  logic                                drop_flag_q, drop_flag_d;
  logic [PTR_W-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]                    level_q, level_d;
  logic [FIFO_DEPTH-1:0][PKT_WIDTH-1:0] mem_q, mem_d;

  logic                 ch_en, full, pop, push, drop;
  logic [PKT_WIDTH-1:0] new_pkt;

  always_comb begin
    ch_en   = ch_enable[acq_channel];
    full    = (level_q == LVL_W'(FIFO_DEPTH));
    pop     = (level_q != '0) && pkt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a sample.
    push    = acq_valid && ch_en && (!full || pop);
    drop    = acq_valid && ch_en && full && !pop;
    new_pkt = {ts_q, acq_channel, acq_data, seq_q, drop_flag_q, 3'b000};

    ts_d        = ts_q + 1'b1;
    seq_d       = seq_q;
    drop_flag_d = drop_flag_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    mem_d       = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = new_pkt;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      seq_d           = seq_q + 1'b1;
      drop_flag_d     = 1'b0;
    end else if (drop) begin
      drop_flag_d = 1'b1;
    end

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge sensor_clk) begin
    if (sensor_rst) begin
      ts_q        <= '0;
      seq_q       <= '0;
      drop_flag_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      mem_q       <= '0;
    end else begin
      ts_q        <= ts_d;
      seq_q       <= seq_d;
      drop_flag_q <= drop_flag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      mem_q       <= mem_d;
    end
  end

  assign pkt_data   = mem_q[rd_ptr_q];
  assign pkt_valid  = (level_q != '0);
  assign fifo_level = level_q;

`ifdef NFB_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge sensor_clk) begin
    if (sensor_rst) drop_cnt_q <= '0;
    else            drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_neural_frame_builder.sv
// Scoreboard bench for neural_frame_builder: directed stimulus pushes expected packets,
// negedge monitors pop and compare. A second instance with a 6-bit timestamp exercises wrap.
`timescale 1ns/1ps
module tb_neural_frame_builder;
  localparam int DW  = 16;
  localparam int CW  = 4;
  localparam int TW  = 32;
  localparam int SW  = 8;
  localparam int FD  = 8;
  localparam int PW  = TW + CW + DW + SW + 4;
  localparam int TW2 = 6;
  localparam int PW2 = TW2 + CW + DW + SW + 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  acq_data = '0;
  logic [CW-1:0]  acq_channel = '0;
  logic           acq_valid = 1'b0;
  logic [15:0]    ch_enable = '1;
  logic           pkt_ready = 1'b0;
  logic [PW-1:0]  pkt_data;
  logic           pkt_valid;
  logic [3:0]     fifo_level;
  logic [PW2-1:0] pkt_data2;
  logic           pkt_valid2;
  logic [3:0]     fifo_level2;
`ifdef NFB_DROP_CNT_EN
  logic [15:0]    drop_count, drop_count2;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0]    cyc_cnt = '0;
  logic [PW-1:0]  exp_q[$];
  logic [PW2-1:0] exp2_q[$];
  logic [PW-1:0]  e1, held;
  logic [PW2-1:0] e2;
  logic           stall_q = 1'b0;

  always #5 clk = ~clk;

  neural_frame_builder #(.DATA_WIDTH(DW), .CH_ID_WIDTH(CW), .TS_WIDTH(TW),
                         .SEQ_WIDTH(SW), .FIFO_DEPTH(FD)) dut (
    .sensor_clk(clk), .sensor_rst(rst), .acq_data(acq_data), .acq_channel(acq_channel),
    .acq_valid(acq_valid), .ch_enable(ch_enable), .pkt_data(pkt_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .fifo_level(fifo_level)
`ifdef NFB_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  neural_frame_builder #(.DATA_WIDTH(DW), .CH_ID_WIDTH(CW), .TS_WIDTH(TW2),
                         .SEQ_WIDTH(SW), .FIFO_DEPTH(FD)) u_ts (
    .sensor_clk(clk), .sensor_rst(rst), .acq_data(acq_data), .acq_channel(acq_channel),
    .acq_valid(acq_valid), .ch_enable(ch_enable), .pkt_data(pkt_data2),
    .pkt_valid(pkt_valid2), .pkt_ready(pkt_ready), .fifo_level(fifo_level2)
`ifdef NFB_DROP_CNT_EN
    , .drop_count(drop_count2)
`endif
  );

  // Expected timestamp: cycles since the last reset edge.
  always @(posedge clk) cyc_cnt <= rst ? 32'd0 : cyc_cnt + 32'd1;

  always @(negedge clk) begin
    if (!rst && pkt_valid && pkt_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pkt_unexpected: got %h expected none", pkt_data);
      end else begin
        e1 = exp_q.pop_front();
        if (pkt_data !== e1) begin
          bad++;
          $display("FAIL pkt: got %h expected %h", pkt_data, e1);
        end
      end
    end
    if (!rst && stall_q && pkt_valid) begin
      total++;
      if (pkt_data !== held) begin
        bad++;
        $display("FAIL hold: got %h expected %h", pkt_data, held);
      end
    end
    stall_q = !rst && pkt_valid && !pkt_ready;
    held    = pkt_data;
  end

  always @(negedge clk) begin
    if (!rst && pkt_valid2 && pkt_ready) begin
      total++;
      if (exp2_q.size() == 0) begin
        bad++;
        $display("FAIL pkt_ts6_unexpected: got %h expected none", pkt_data2);
      end else begin
        e2 = exp2_q.pop_front();
        if (pkt_data2 !== e2) begin
          bad++;
          $display("FAIL pkt_ts6: got %h expected %h", pkt_data2, e2);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus; acc says whether the sample must be accepted.
  task automatic tick(input logic v, input logic [3:0] ch, input logic [15:0] d,
                      input logic rdy, input logic acc, input logic [7:0] sq, input logic fl);
    acq_valid = v; acq_channel = ch; acq_data = d; pkt_ready = rdy;
    if (acc) begin
      exp_q.push_back({cyc_cnt, ch, d, sq, fl, 3'b000});
      exp2_q.push_back({cyc_cnt[TW2-1:0], ch, d, sq, fl, 3'b000});
    end
    @(posedge clk); #1;
  endtask

  // Reset with live traffic on the inputs, which must be ignored.
  task automatic do_reset();
    rst = 1'b1; acq_valid = 1'b1; acq_channel = 4'd3; acq_data = 16'h5555; pkt_ready = 1'b1;
    exp_q.delete(); exp2_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; acq_valid = 1'b0; pkt_ready = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 64) begin
      tick(1'b0, 4'd0, 16'd0, 1'b1, 1'b0, 8'd0, 1'b0);
      n++;
    end
    check("drain_done", 64'(exp_q.size() == 0 && exp2_q.size() == 0), 64'd1);
    check("drain_level", 64'(fifo_level), 64'd0);
    check("drain_valid", 64'(pkt_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("rst_valid", 64'(pkt_valid), 64'd0);
    check("rst_data", 64'(pkt_data), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
`ifdef NFB_DROP_CNT_EN
    check("rst_drop_count", 64'(drop_count), 64'd0);
`endif

    // First packet after reset: ts 0, seq 0, visible next cycle.
    tick(1'b1, 4'd3, 16'hABCD, 1'b1, 1'b1, 8'd0, 1'b0);
    check("first_valid", 64'(pkt_valid), 64'd1);
    check("first_data", 64'(pkt_data), {32'd0, 4'd3, 16'hABCD, 8'd0, 4'b0000});
    drain();

    // Overflow: 8 fit, 2 dropped; full+pop accepts with drop flag set.
    do_reset();
    for (int i = 0; i < 10; i++)
      tick(1'b1, 4'd1, 16'h1000 + 16'(i), 1'b0, i < 8, 8'(i), 1'b0);
    check("full_level", 64'(fifo_level), 64'd8);
    check("full_valid", 64'(pkt_valid), 64'd1);
`ifdef NFB_DROP_CNT_EN
    check("drop_count_2", 64'(drop_count), 64'd2);
`endif
    tick(1'b1, 4'd1, 16'h2222, 1'b1, 1'b1, 8'd8, 1'b1);
    check("pushpop_level", 64'(fifo_level), 64'd8);
`ifdef NFB_DROP_CNT_EN
    check("pushpop_no_drop", 64'(drop_count), 64'd2);
`endif
    drain();

    // Disabled channel while full: no drop, no flag, no seq step.
    do_reset();
    ch_enable = 16'hFFDF;
    for (int i = 0; i < 8; i++)
      tick(1'b1, 4'd4, 16'h4000 + 16'(i), 1'b0, 1'b1, 8'(i), 1'b0);
    tick(1'b1, 4'd5, 16'h4500, 1'b0, 1'b0, 8'd0, 1'b0);
`ifdef NFB_DROP_CNT_EN
    check("disabled_no_drop", 64'(drop_count), 64'd0);
`endif
    check("disabled_level", 64'(fifo_level), 64'd8);
    tick(1'b1, 4'd4, 16'h4008, 1'b1, 1'b1, 8'd8, 1'b0);
    drain();

    // Only channel 0 enabled; seq stays contiguous.
    do_reset();
    ch_enable = 16'h0001;
    for (int i = 0; i < 6; i++)
      tick(1'b1, 4'(i % 2), 16'h3000 + 16'(i), 1'b1, (i % 2) == 0, 8'(i / 2), 1'b0);
    drain();
    ch_enable = '1;

    // 300 packets: seq wraps 255->0; the 6-bit timestamp instance wraps repeatedly.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 4'd2, 16'(i), 1'b1, 1'b1, 8'(i), 1'b0);
      if (i == 255) check("seq_255", 64'(pkt_data[11:4]), 64'd255);
      if (i == 256) check("seq_wrap", 64'(pkt_data[11:4]), 64'd0);
    end
    drain();

    // Reset with 5 queued packets discards them; seq restarts at 0.
    do_reset();
    for (int i = 0; i < 5; i++)
      tick(1'b1, 4'd6, 16'h6000 + 16'(i), 1'b0, 1'b1, 8'(i), 1'b0);
    check("five_level", 64'(fifo_level), 64'd5);
    do_reset();
    check("rst2_level", 64'(fifo_level), 64'd0);
    check("rst2_valid", 64'(pkt_valid), 64'd0);
    check("rst2_data", 64'(pkt_data), 64'd0);
    tick(1'b1, 4'd7, 16'hBEEF, 1'b1, 1'b1, 8'd0, 1'b0);
    check("rst2_first", 64'(pkt_data), {32'd0, 4'd7, 16'hBEEF, 8'd0, 4'b0000});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neural_frame_builder.md
NEURAL_FRAME_BUILDER -- requirements
Module: neural_frame_builder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: sample width.
REQ-002 SHALL have parameter CH_ID_WIDTH, default 4: channel-ID width; NUM_CH = 2**CH_ID_WIDTH.
REQ-003 SHALL have parameter TS_WIDTH, default 32: timestamp counter width.
REQ-004 SHALL have parameter SEQ_WIDTH, default 8: sequence-number width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8: packet FIFO entries, power of two, min 2.
REQ-006 SHALL derive PKT_WIDTH = TS_WIDTH+CH_ID_WIDTH+DATA_WIDTH+SEQ_WIDTH+4 (64 at defaults).
REQ-007 SHALL have ports:
- sensor_clk, in, 1: sole clock.
- sensor_rst, in, 1: synchronous, active-high reset.
- acq_data, in, DATA_WIDTH: sample.
- acq_channel, in, CH_ID_WIDTH: sample channel.
- acq_valid, in, 1: sample strobe; no backpressure.
- ch_enable, in, NUM_CH: per-channel accept mask.
- pkt_data, out, PKT_WIDTH: FIFO head packet.
- pkt_valid, out, 1: head valid.
- pkt_ready, in, 1: downstream accept.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: occupied entries.
- drop_count, out, 16: present only with NFB_DROP_CNT_EN.

Function
REQ-008 SHALL increment timestamp every cycle, wrapping 2**TS_WIDTH-1 -> 0.
REQ-009 SHALL pack {timestamp, acq_channel, acq_data, seq, drop_flag, 3'b000}, MSB first; timestamp = counter value in the acq_valid cycle.
REQ-010 SHALL accept a sample when acq_valid=1, ch_enable[acq_channel]=1, and FIFO not full or a pop occurs that cycle.
REQ-011 SHALL silently discard a sample on a disabled channel: no push, no seq increment, no drop count.
REQ-012 SHALL drop an enabled sample arriving when full with no same-cycle pop, setting pending drop_flag.
REQ-013 SHALL stamp pending drop_flag=1 into the next accepted packet, then clear it.
REQ-014 SHALL assign seq from a counter, incremented per accepted packet only, wrapping at 2**SEQ_WIDTH; first packet after reset carries seq 0.
REQ-015 SHALL pop when pkt_valid && pkt_ready.
REQ-016 SHALL drive pkt_valid = (fifo_level != 0).
REQ-017 SHALL keep pkt_data stable while pkt_valid && !pkt_ready.
REQ-018 SHALL present a packet accepted in cycle N on pkt_data with pkt_valid=1 in cycle N+1 when FIFO was empty.
REQ-019 SHALL leave fifo_level unchanged on simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-020 SHALL never exceed FIFO_DEPTH or underflow; pkt_ready with empty FIFO is ignored.
REQ-021 SHALL deliver packets in acceptance order.

Reset
REQ-022 SHALL, while sensor_rst=1 at a sensor_clk edge, clear timestamp, seq, drop_flag, FIFO pointers and contents, and drop_count to 0.
REQ-023 SHALL hold pkt_valid=0, pkt_data=0, fifo_level=0 the cycle after a reset edge, discarding in-flight packets.
REQ-024 SHALL ignore acq_valid and pkt_ready in any cycle sensor_rst=1.

Configuration
REQ-025 SHALL, with NFB_DROP_CNT_EN defined, expose drop_count: +1 per REQ-012 drop, saturating at 16'hFFFF.
REQ-026 SHALL, without NFB_DROP_CNT_EN, omit the drop_count port and counter; drop_flag behaviour unchanged.

Verification
REQ-027 Reset release, acq_valid on ch 3, data 16'hABCD, pkt_ready=1 -> next cycle pkt_valid=1, ch=3, data=16'hABCD, seq=0, drop_flag=0, ts = capture-cycle count.
REQ-028 pkt_ready=0, 10 enabled samples on ch 1 -> fifo_level=8; packets 9,10 dropped; drop_count=2 (macro on); next accepted packet drop_flag=1, seq=8.
REQ-029 FIFO full, pkt_ready=1 and acq_valid same cycle -> sample accepted, fifo_level stays 8, no drop.
REQ-030 ch_enable=16'h0001, samples alternate ch 0/ch 1 -> only ch 0 packets, seq contiguous 0,1,2...
REQ-031 300 accepted packets, default widths -> seq wraps 255->0; force ts near 2**32-1 -> wraps to 0, fields intact.
REQ-032 sensor_rst for 1 cycle with FIFO at 5 entries -> next cycle fifo_level=0, pkt_valid=0; next packet seq=0.
